// File: rtl/floo_pkg.sv
// Shared router types: VC id carried between VC selection, switch allocation
// and the per-port credit trackers.
package floo_pkg;

   localparam int unsigned VcIdWidth = 2;

   typedef logic [VcIdWidth-1:0] vc_id_t;

endpackage

// File: rtl/floo_vc_credit_cnt.sv
// Single saturating up/down credit counter for one downstream VC; flags an
// error pulse when a decrement at zero or an increment at Depth is attempted.
module floo_vc_credit_cnt
   import floo_pkg::*;
#(
   parameter int unsigned Depth    = 2,
   parameter int unsigned CntWidth = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                inc,
   input  logic                dec,
   output logic [CntWidth-1:0] cnt,
   output logic                err
);

   localparam logic [CntWidth-1:0] MaxCnt = CntWidth'(Depth);

   logic underflow;
   logic overflow;

   // Coincident inc/dec cancel out, so they are legal even at either bound.
   assign underflow = dec && !inc && (cnt == '0);
   assign overflow  = inc && !dec && (cnt == MaxCnt);
   assign err       = underflow || overflow;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= MaxCnt;
      end else if (dec && !inc && !underflow) begin
         cnt <= cnt - 1'b1;
      end else if (inc && !dec && !overflow) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/floo_vc_credit_tracker.sv
// Per-output-port credit tracker: one counter per downstream VC, not-full
// vector for VC selection, sticky error flag. Optional FLOO_VC_CREDIT_BYPASS_EN.
module floo_vc_credit_tracker
   import floo_pkg::*;
#(
   parameter int unsigned NumVC         = 4,
   parameter int unsigned NumVCWidth    = NumVC > 1 ? $clog2(NumVC) : 1,
   parameter int unsigned NumVCWidthMax = 2,
   parameter int unsigned VCDepth       = 2,
   parameter int unsigned DeeperVCId    = 0,
   parameter int unsigned DeeperVCDepth = 3,
   parameter int unsigned CntWidth      = $clog2(DeeperVCDepth + 1)
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      consume_v_i,
   input  logic [NumVCWidthMax-1:0]  consume_id_i,
   input  logic [NumVC-1:0]          credit_v_i,
   output logic [NumVC-1:0]          vc_not_full_o,
   output logic [NumVC*CntWidth-1:0] credit_cnt_o,
   output logic                      err_o
);

   logic [NumVCWidth-1:0] id_lo;
   logic                  id_ok;
   logic                  oor_err;
   logic [NumVC-1:0]      dec;
   logic [NumVC-1:0]      cnt_err;
   logic [NumVC-1:0]      nf_reg;
   logic                  any_err;

   assign id_lo   = consume_id_i[NumVCWidth-1:0];
   assign id_ok   = (NumVC == 1) || (32'(id_lo) < NumVC);
   assign oor_err = consume_v_i && !id_ok;

   for (genvar v = 0; v < NumVC; v++) begin : gen_vc
      localparam int unsigned Depth = (v == DeeperVCId) ? DeeperVCDepth : VCDepth;

      logic [CntWidth-1:0] cnt;

      // A single-VC port ignores the id entirely.
      assign dec[v] = consume_v_i && id_ok &&
                      ((NumVC == 1) || (id_lo == NumVCWidth'(v)));

      floo_vc_credit_cnt #(
         .Depth    (Depth),
         .CntWidth (CntWidth)
      ) i_cnt (
         .clk (clk_i),
         .rst (rst_i),
         .inc (credit_v_i[v]),
         .dec (dec[v]),
         .cnt (cnt),
         .err (cnt_err[v])
      );

      assign credit_cnt_o[v*CntWidth +: CntWidth] = cnt;
      assign nf_reg[v] = (cnt != '0);
   end

   assign any_err = oor_err || (|cnt_err);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         err_o <= 1'b0;
      end else if (any_err) begin
         err_o <= 1'b1;
      end
   end

`ifdef FLOO_VC_CREDIT_BYPASS_EN
   // A returning credit is spendable in the cycle it arrives.
   assign vc_not_full_o = nf_reg | credit_v_i;
`else
   assign vc_not_full_o = nf_reg;
`endif

endmodule

// File: tb/tb_floo_vc_credit_tracker.sv
// Scoreboard bench for floo_vc_credit_tracker (NumVC=4, VCDepth=2, deeper VC0 depth 3).
module tb_floo_vc_credit_tracker;
   import floo_pkg::*;

   typedef struct packed {
      logic [7:0] cnt;
      logic [3:0] nf;
      logic       err;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       consume_v = 1'b0;
   vc_id_t     consume_id = '0;
   logic [3:0] credit_v = '0;
   logic [3:0] vc_not_full;
   logic [7:0] credit_cnt;
   logic       err;

   exp_t q[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   floo_vc_credit_tracker #(
      .NumVC         (4),
      .NumVCWidthMax (2),
      .VCDepth       (2),
      .DeeperVCId    (0),
      .DeeperVCDepth (3)
   ) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .consume_v_i   (consume_v),
      .consume_id_i  (consume_id),
      .credit_v_i    (credit_v),
      .vc_not_full_o (vc_not_full),
      .credit_cnt_o  (credit_cnt),
      .err_o         (err)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] pk(input int c3, input int c2, input int c1, input int c0);
      return {2'(c3), 2'(c2), 2'(c1), 2'(c0)};
   endfunction

   function automatic logic [3:0] nf_of(input logic [7:0] c);
      logic [3:0] r;
      for (int i = 0; i < 4; i++) r[i] = (c[2*i +: 2] != 2'd0);
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
      end
   endtask

   // Drive one cycle of stimulus and queue the state expected after the next edge.
   task automatic step(input logic cv, input int id, input logic [3:0] cr,
                       input logic [7:0] ecnt, input logic eerr);
      exp_t e;
      @(negedge clk);
      consume_v  = cv;
      consume_id = 2'(id);
      credit_v   = cr;
      e.cnt = ecnt;
      e.nf  = nf_of(ecnt);
`ifdef FLOO_VC_CREDIT_BYPASS_EN
      e.nf  = e.nf | cr;
`endif
      e.err = eerr;
      q.push_back(e);
   endtask

   // Monitor: compare the registered state just after every rising edge.
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (q.size() > 0) begin
         e = q.pop_front();
         chk("credit_cnt", 32'(credit_cnt), 32'(e.cnt));
         chk("vc_not_full", 32'(vc_not_full), 32'(e.nf));
         chk("err", 32'(err), 32'(e.err));
      end
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      int waited;
      #12;
      chk("reset_cnt", 32'(credit_cnt), 32'(pk(2,2,2,3)));
      chk("reset_nf", 32'(vc_not_full), 32'hF);
      chk("reset_err", 32'(err), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      step(0, 0, 4'b0000, pk(2,2,2,3), 0);
      // VC0 drained to zero
      step(1, 0, 4'b0000, pk(2,2,2,2), 0);
      step(1, 0, 4'b0000, pk(2,2,2,1), 0);
      step(1, 0, 4'b0000, pk(2,2,2,0), 0);
      // VC1 to zero, then simultaneous consume+credit at zero
      step(1, 1, 4'b0000, pk(2,2,1,0), 0);
      step(1, 1, 4'b0000, pk(2,2,0,0), 0);
      step(1, 1, 4'b0010, pk(2,2,0,0), 0);
      step(0, 0, 4'b0010, pk(2,2,1,0), 0);
      // VC2 underflow sets sticky err
      step(1, 2, 4'b0000, pk(2,1,1,0), 0);
      step(1, 2, 4'b0000, pk(2,0,1,0), 0);
      step(1, 2, 4'b0000, pk(2,0,1,0), 1);
      for (int i = 0; i < 10; i++) step(0, 0, 4'b0000, pk(2,0,1,0), 1);
      // asynchronous reset mid-operation
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("async_rst_cnt", 32'(credit_cnt), 32'(pk(2,2,2,3)));
      chk("async_rst_err", 32'(err), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      step(0, 0, 4'b0000, pk(2,2,2,3), 0);
      // reach VC0..VC3 = {1,0,2,1}
      step(1, 0, 4'b0000, pk(2,2,2,2), 0);
      step(1, 0, 4'b0000, pk(2,2,2,1), 0);
      step(1, 1, 4'b0000, pk(2,2,1,1), 0);
      step(1, 1, 4'b0000, pk(2,2,0,1), 0);
      step(1, 3, 4'b0000, pk(1,2,0,1), 0);
      // all credits back: VC2 overflows and saturates
      step(0, 0, 4'b1111, pk(2,2,1,2), 1);
      // drain VC3, then credit return on it
      step(1, 3, 4'b0000, pk(1,2,1,2), 1);
      step(1, 3, 4'b0000, pk(0,2,1,2), 1);
      step(0, 0, 4'b1000, pk(1,2,1,2), 1);
      #1;
`ifdef FLOO_VC_CREDIT_BYPASS_EN
      chk("bypass_nf3", 32'(vc_not_full[3]), 32'd1);
`else
      chk("bypass_nf3", 32'(vc_not_full[3]), 32'd0);
`endif
      step(0, 0, 4'b0000, pk(1,2,1,2), 1);
      waited = 0;
      while (q.size() > 0 && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      chk("scoreboard_drained", 32'(q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/floo_vc_credit_tracker.md
Name: floo_vc_credit_tracker

Overview:
- Per-output-port credit tracker for the VC router.
- Keeps one credit counter per downstream VC.
- Decrements a counter when a flit is sent into that VC; increments it on credit return from the downstream router.
- Drives the per-VC not-full vector consumed directly by the FVADA VC-selection stage.
- One instance per router output port.

Parameters:
- NumVC, 4, number of VCs on this output port.
- NumVCWidth, NumVC>1 ? $clog2(NumVC) : 1, index width.
- NumVCWidthMax, 2, padded VC id width used router-wide; must be ≥ NumVCWidth.
- VCDepth, 2, downstream buffer depth of every non-deeper VC.
- DeeperVCId, 0, index of the VC with the deeper downstream buffer.
- DeeperVCDepth, 3, downstream depth of VC DeeperVCId; must be ≥ VCDepth.
- CntWidth, $clog2(DeeperVCDepth+1), counter width.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous reset, active-high.
- consume_v_i  in  1  a flit leaves this port this cycle.
- consume_id_i  in  NumVCWidthMax  VC the flit is sent into (upper pad bits ignored).
- credit_v_i  in  NumVC  per-VC credit return from downstream, one credit per set bit per cycle.
- vc_not_full_o  out  NumVC  VC has ≥1 credit; feeds the VC-selection stage.
- credit_cnt_o  out  NumVC*CntWidth  current credit count per VC.
- err_o  out  1  sticky protocol-error flag.

Behaviour:
- Interface: one clock, clk_i; reset rst_i is asynchronous and active-high.
- Reset values:
  - cnt[DeeperVCId] = DeeperVCDepth; every other cnt[v] = VCDepth.
  - vc_not_full_o = all ones.
  - err_o = 0.
- Per-VC update each cycle, with dec = consume_v_i && consume_id_i[NumVCWidth-1:0]==v and inc = credit_v_i[v]:
  - dec && !inc: cnt−1.
  - inc && !dec: cnt+1.
  - both or neither: cnt unchanged. Simultaneous consume and return on the same VC is legal even at cnt==0 or cnt==max.
- Latency:
  - credit_cnt_o and vc_not_full_o are registered-count derived: vc_not_full_o[v] = (cnt[v] != 0).
  - A consume in cycle N is visible in cycle N+1. A credit return in cycle N is visible in cycle N+1.
- Protocol errors; in each case the counter saturates (does not change) and err_o sets:
  - Underflow: dec && !inc && cnt==0.
  - Overflow: inc && !dec && cnt==max, where max is that VC's depth.
- err_o:
  - Sets in the cycle after the offending event.
  - Stays high until reset.
  - Never clears while rst_i is low.
- Out-of-range id: consume_id_i ≥ NumVC with consume_v_i is an error. err_o sets and no counter changes.
- Reset mid-operation: all counters return to full depth immediately (asynchronous). Any in-flight credits after reset release are the system's responsibility.
- NumVC==1: consume_id_i is ignored; the single counter uses DeeperVCDepth if DeeperVCId==0.
- No handshake back-pressure: consume_v_i is trusted to be issued only for VCs that FVADA selected.

Optional Feature:
- Macro: FLOO_VC_CREDIT_BYPASS_EN.
- Defined: vc_not_full_o[v] = (cnt[v]!=0) || credit_v_i[v]. A returning credit is usable in the same cycle, saving one cycle of round-trip latency. Combinational path from credit_v_i to vc_not_full_o.
- Undefined: purely registered output as above. credit_cnt_o and err_o are identical in both builds.

Decomposition:
- Package floo_pkg:
  - Add vc_id_t (logic [NumVCWidthMax-1:0]) shared with the VC-selection stage and the switch allocator.
  - No new enums.
- Sub-module floo_vc_credit_cnt: single saturating up/down counter with parameters Depth and CntWidth. Inputs inc/dec; outputs cnt and err pulse. Instantiated NumVC times in a generate loop, with Depth = DeeperVCDepth for v==DeeperVCId.
- Top level: id decode, error OR-reduction, sticky err register, optional bypass.

Test Plan (NumVC=4, VCDepth=2, DeeperVCId=0, DeeperVCDepth=3):
- Reset release → credit_cnt_o = {2,2,2,3} (VC3..VC0), vc_not_full_o=4'b1111, err_o=0.
- Three consumes to VC0 in consecutive cycles → cnt0 = 2,1,0. vc_not_full_o[0]=0 from the cycle after the third consume; err_o stays 0.
- VC1 at cnt 0; consume_id=1 and credit_v_i[1]=1 in the same cycle → cnt1 stays 0, err_o=0. Next cycle credit only → cnt1=1, vc_not_full_o[1]=1.
- Consume to VC2 at cnt 0 with no credit → cnt2 stays 0, err_o=1 next cycle and remains 1 for 10 idle cycles.
- All four credit_v_i bits set while VC0..VC3 at {1,0,2,1} (VC0..VC3) → VC0..VC3 become {2,1,2,2}: VC0 and VC1 increment by one, VC3 increments to 2, VC2 (already at max 2) stays 2. err_o sets from the VC2 overflow.
- Macro defined; VC3 at 0 with credit_v_i[3]=1 → vc_not_full_o[3]=1 in the same cycle. Undefined build → vc_not_full_o[3]=1 only in the following cycle.
